// File: rtl/inv_key_if.sv
// Handshake and S-box bus bundle for the AES-128 reverse key schedule.
// master = key source / consumer side, slave = inv_key_generator.
interface inv_key_if;
  logic [127:0]        key_last;
  logic                key_last_valid;
  logic                key_last_ready;
  logic [15:0][127:0]  sub_table;
  logic                substitution_table_valid;
  logic [127:0]        key_out;
  logic [3:0]          key_out_round;
  logic                key_out_valid;
  logic                key_out_ready;
  logic                done;
  logic [3:0]          key_rd_addr;
  logic [127:0]        key_rd_data;

  modport master (
    output key_last, key_last_valid, sub_table, substitution_table_valid,
           key_out_ready, key_rd_addr,
    input  key_last_ready, key_out, key_out_round, key_out_valid, done,
           key_rd_data
  );

  modport slave (
    input  key_last, key_last_valid, sub_table, substitution_table_valid,
           key_out_ready, key_rd_addr,
    output key_last_ready, key_out, key_out_round, key_out_valid, done,
           key_rd_data
  );
endinterface

// File: rtl/inv_key_generator.sv
// AES-128 reverse key schedule: walks from round NUM_ROUNDS down to round 0.
// Optional key store enabled by macro INV_KEY_STORE_EN.
//
// state | meaning
// IDLE  | ready for a new last-round key
// LOAD  | present the latched last-round key
// OUT   | key_out valid, waiting for consumer
// CALC  | derive key r-1 once the S-box table is usable
module inv_key_generator #(
  parameter int NUM_ROUNDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  inv_key_if.slave    bus
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {IDLE, LOAD, OUT, CALC} state_t;

  state_t              state, state_nxt;
  logic [127:0]        key_lat;
  logic [3:0]          round_cnt;
  logic [3:0]          round_dec;
  logic                start, accept, calc_go;
  logic [15:0][127:0]  tbl;
  logic [31:0]         w0, w1, w2, w3, w4, w5, w6, w7;
  logic [31:0]         rot_w, sub_w;
  logic [7:0]          sb_in;
  logic [127:0]        key_next;

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    logic [7:0] rc;
    rc = 8'h00;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    accept    = 1'b0;
    calc_go   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.key_last_valid) begin
          start     = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: state_nxt = OUT;
      OUT: begin
        if (bus.key_out_valid && bus.key_out_ready) begin
          accept    = 1'b1;
          state_nxt = (round_cnt == 4'd0) ? IDLE : CALC;
        end
      end
      CALC: begin
        if (bus.substitution_table_valid) begin
          calc_go   = 1'b1;
          state_nxt = OUT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.key_last_ready = (state == IDLE) && !rst;
  assign round_dec          = round_cnt - 4'd1;
  assign tbl                = bus.sub_table;

  // Inverse step: recover the first word of key r-1 through SubWord(RotWord(w3)).
  always_comb begin
    {w4, w5, w6, w7} = bus.key_out;
    w3    = w7 ^ w6;
    w2    = w6 ^ w5;
    w1    = w5 ^ w4;
    rot_w = {w3[23:0], w3[31:24]};
    sub_w = 32'h0;
    sb_in = 8'h00;
    for (int i = 0; i < 4; i++) begin
      sb_in = rot_w[8*i +: 8];
      sub_w[8*i +: 8] = tbl[sb_in[7:4]][{4'hf - sb_in[3:0], 3'b000} +: 8];
    end
    w0       = w4 ^ sub_w ^ {rcon_of(round_cnt), 24'h0};
    key_next = {w0, w1, w2, w3};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_lat           <= '0;
      round_cnt         <= '0;
      bus.key_out       <= '0;
      bus.key_out_round <= '0;
      bus.key_out_valid <= 1'b0;
      bus.done          <= 1'b0;
    end else begin
      bus.done <= accept && (round_cnt == 4'd0);
      if (start) begin
        key_lat   <= bus.key_last;
        round_cnt <= LAST_ROUND;
      end
      if (state == LOAD) begin
        bus.key_out       <= key_lat;
        bus.key_out_round <= LAST_ROUND;
        bus.key_out_valid <= 1'b1;
      end
      if (accept) bus.key_out_valid <= 1'b0;
      if (calc_go) begin
        bus.key_out       <= key_next;
        bus.key_out_round <= round_dec;
        bus.key_out_valid <= 1'b1;
        round_cnt         <= round_dec;
      end
    end
  end

`ifdef INV_KEY_STORE_EN
  logic [NUM_ROUNDS:0][127:0] key_file;

  // Survives a new start on purpose; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_file <= '0;
    end else if (state == LOAD) begin
      key_file[NUM_ROUNDS] <= key_lat;
    end else if (calc_go) begin
      for (int i = 0; i < NUM_ROUNDS; i++) begin
        if (round_dec == 4'(i)) key_file[i] <= key_next;
      end
    end
  end

  always_comb begin
    bus.key_rd_data = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      if (bus.key_rd_addr == 4'(i)) bus.key_rd_data = key_file[i];
    end
  end
`else
  logic unused_rd_addr;
  assign unused_rd_addr  = ^bus.key_rd_addr;
  assign bus.key_rd_data = '0;
`endif

endmodule
